// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ instruction sequencer.
//   state_e           - sequencer state encoding (3 bits)
//   INSN_LEN          - bytes per instruction (A, B, C)
//   DEFAULT_START_ADR - PC value after reset / restart
//   DEFAULT_HALT_ADR  - taken-branch target that halts the CPU
package subleq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_F2   = 3'd3,
        ST_RA   = 3'd4,
        ST_RB   = 3'd5,
        ST_EX   = 3'd6,
        ST_HALT = 3'd7
    } state_e;

    localparam int unsigned INSN_LEN          = 3;
    localparam logic [7:0]  DEFAULT_START_ADR = 8'h00;
    localparam logic [7:0]  DEFAULT_HALT_ADR  = 8'hFF;

endpackage

// File: rtl/subleq_seq.sv
// SUBLEQ instruction sequencer: sole master of the 8x256 program/data RAM.
// Each instruction takes six cycles (F0..EX): fetch A, B, C at pc, read
// mem[A] and mem[B], write mem[B]-mem[A] to mem[B], then branch to C when the
// result is <= 0 (signed), else fall through to pc+3.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   run                   - level; 1 executes, 0 stops at the next boundary
//   restart               - pulse; in IDLE/HALT reloads pc and clears halt
//   ram_radr / ram_rdata  - RAM read port (address registered inside RAM,
//                           data valid the following cycle)
//   ram_wadr / ram_wdata / ram_wen - RAM write port, active only in EX
//   pc                    - registered program counter
//   busy / halted         - status: executing / stopped on HALT_ADR
//   insn_done             - one-cycle pulse in the EX cycle
module subleq_seq
    import subleq_pkg::*;
#(
    parameter logic [7:0] START_ADR = DEFAULT_START_ADR,
    parameter logic [7:0] HALT_ADR  = DEFAULT_HALT_ADR
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       restart,
    output logic [7:0] ram_radr,
    input  logic [7:0] ram_rdata,
    output logic [7:0] ram_wadr,
    output logic [7:0] ram_wdata,
    output logic       ram_wen,
    output logic [7:0] pc,
    output logic       busy,
    output logic       halted,
    output logic       insn_done
);

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;
    logic [7:0] c_q, c_d;
    logic [7:0] ma_q, ma_d;

    logic [7:0] res;
    logic       leq;

    // In EX, ram_rdata carries mem[B] (address issued in RB); ma_q holds mem[A].
    assign res = ram_rdata - ma_q;
    // Signed "less than or equal to zero": zero, or sign bit set.
    assign leq = (res == 8'h00) | res[7];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= START_ADR;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            c_q     <= 8'h00;
            ma_q    <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its neighbours, independent of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            ma_q    <= ma_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // of the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        ma_d      = ma_q;
        ram_radr  = pc_q;
        ram_wen   = 1'b0;
        ram_wadr  = 8'h00;
        ram_wdata = 8'h00;
        insn_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // restart and run together: start fetching from the reloaded pc.
                if (restart) pc_d = START_ADR;
                if (run)     state_d = ST_F0;
            end
            ST_F0: begin
                state_d = ST_F1;
            end
            ST_F1: begin
                ram_radr = pc_q + 8'd1;
                a_d      = ram_rdata;
                state_d  = ST_F2;
            end
            ST_F2: begin
                ram_radr = pc_q + 8'd2;
                b_d      = ram_rdata;
                state_d  = ST_RA;
            end
            ST_RA: begin
                ram_radr = a_q;
                c_d      = ram_rdata;
                state_d  = ST_RB;
            end
            ST_RB: begin
                ram_radr = b_q;
                ma_d     = ram_rdata;
                state_d  = ST_EX;
            end
            ST_EX: begin
                ram_wen   = 1'b1;
                ram_wadr  = b_q;
                ram_wdata = res;
                insn_done = 1'b1;
                pc_d      = leq ? c_q : pc_q + 8'(INSN_LEN);
                // Only a taken branch to HALT_ADR halts; falling through onto
                // HALT_ADR just executes from there.
                if (leq && (c_q == HALT_ADR)) state_d = ST_HALT;
                else if (!run)                state_d = ST_IDLE;
                else                          state_d = ST_F0;
            end
            ST_HALT: begin
                if (restart) begin
                    pc_d    = START_ADR;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign pc     = pc_q;
    assign busy   = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_subleq_seq.sv
// Self-checking bench for subleq_seq. A behavioural RAM (registered read
// address, asynchronous data) sits on each DUT. Expected writes and the pc
// that follows each instruction go into a scoreboard queue when a program is
// loaded; a monitor pops and compares on every EX cycle.
module tb_subleq_seq;

    typedef struct packed {
        logic [7:0] wadr;
        logic [7:0] wdata;
        logic [7:0] pc;
        logic       halt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, run, restart;
    logic [7:0] ram_radr, ram_rdata, ram_wadr, ram_wdata, pc;
    logic       ram_wen, busy, halted, insn_done;

    logic       run2, restart2;
    logic [7:0] radr2, rdata2, wadr2, wdata2, pc2;
    logic       wen2, busy2, halted2, done2;

    subleq_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .restart   (restart),
        .ram_radr  (ram_radr),
        .ram_rdata (ram_rdata),
        .ram_wadr  (ram_wadr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .pc        (pc),
        .busy      (busy),
        .halted    (halted),
        .insn_done (insn_done)
    );

    subleq_seq #(.START_ADR(8'hFE)) dut_fe (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run2),
        .restart   (restart2),
        .ram_radr  (radr2),
        .ram_rdata (rdata2),
        .ram_wadr  (wadr2),
        .ram_wdata (wdata2),
        .ram_wen   (wen2),
        .pc        (pc2),
        .busy      (busy2),
        .halted    (halted2),
        .insn_done (done2)
    );

    // RAM models: both memories written only from this process.
    logic [7:0] mem  [256];
    logic [7:0] mem2 [256];
    logic [7:0] radr_q, radr2_q;
    logic       mem_clr, ld_en;
    logic [7:0] ld_adr, ld_dat;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) begin
                mem[i]  <= 8'h00;
                mem2[i] <= 8'h00;
            end
        end else begin
            if (ld_en)   mem[ld_adr]    <= ld_dat;
            if (ram_wen) mem[ram_wadr]  <= ram_wdata;
            if (wen2)    mem2[wadr2]    <= wdata2;
        end
        radr_q  <= ram_radr;
        radr2_q <= radr2;
    end

    assign ram_rdata = mem[radr_q];
    assign rdata2    = mem2[radr2_q];

    int   n_checks = 0;
    int   n_fails  = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t cur;
    logic pc_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard monitor: compare each EX write, then the pc one cycle later.
    always @(negedge clk) begin
        if (pc_pending) begin
            check("pc_after", pc, cur.pc);
            check("halted_after", halted, cur.halt);
            pc_pending = 1'b0;
        end
        if (ram_wen || insn_done) begin
            done_cnt++;
            check("ex_wen", ram_wen, 1);
            check("ex_done", insn_done, 1);
            check("sb_entry", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                cur = sb.pop_front();
                check("wadr", ram_wadr, cur.wadr);
                check("wdata", ram_wdata, cur.wdata);
                pc_pending = 1'b1;
            end
        end
    end

    task automatic load(input logic [7:0] adr, input logic [7:0] dat);
        ld_en  = 1'b1;
        ld_adr = adr;
        ld_dat = dat;
        @(negedge clk);
        ld_en  = 1'b0;
    endtask

    task automatic wait_wen(input string tag, output int cyc);
        cyc = 1;
        while (ram_wen !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, ram_wen, 1);
    endtask

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int d0;
        rst_n = 1'b0; run = 1'b0; restart = 1'b0;
        run2 = 1'b0; restart2 = 1'b0;
        mem_clr = 1'b1; ld_en = 1'b0; ld_adr = 8'h00; ld_dat = 8'h00;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_wen", ram_wen, 0);
        check("rst_done", insn_done, 0);
        check("rst_pc", pc, 8'h00);
        check("rst_radr", ram_radr, 8'h00);
        check("rst_wadr", ram_wadr, 8'h00);
        check("rst_wdata", ram_wdata, 8'h00);
        check("rst_pc_fe", pc2, 8'hFE);
        mem_clr = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        // 1: taken branch, 6-cycle latency, single insn_done
        load(8'h00, 8'h10); load(8'h01, 8'h11); load(8'h02, 8'h06);
        load(8'h10, 8'h05); load(8'h11, 8'h03);
        sb.push_back('{wadr: 8'h11, wdata: 8'hFE, pc: 8'h06, halt: 1'b0});
        d0  = done_cnt;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        check("t1_busy_f0", busy, 1);
        check("t1_radr_f0", ram_radr, 8'h00);
        wait_wen("t1_wen", cyc);
        check("t1_latency", cyc, 6);
        @(negedge clk);
        check("t1_idle", busy, 0);
        check("t1_done_once", done_cnt - d0, 1);
        check("t1_mem", mem[8'h11], 8'hFE);

        // 2: not taken, back-to-back fetch from pc+3; restart+run together
        load(8'h10, 8'h02); load(8'h11, 8'h07);
        sb.push_back('{wadr: 8'h11, wdata: 8'h05, pc: 8'h03, halt: 1'b0});
        sb.push_back('{wadr: 8'h00, wdata: 8'h00, pc: 8'h00, halt: 1'b0});
        restart = 1'b1;
        run     = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t2_radr_reload", ram_radr, 8'h00);
        wait_wen("t2_wen1", cyc);
        @(negedge clk);
        check("t2_next_fetch", ram_radr, 8'h03);
        check("t2_busy", busy, 1);
        run = 1'b0;
        wait_wen("t2_wen2", cyc);
        @(negedge clk);
        check("t2_idle", busy, 0);

        // 3: halt via taken branch to FF, run ignored, restart
        load(8'h00, 8'h10); load(8'h01, 8'h10); load(8'h02, 8'hFF); load(8'h10, 8'h33);
        sb.push_back('{wadr: 8'h10, wdata: 8'h00, pc: 8'hFF, halt: 1'b1});
        run = 1'b1;
        wait_wen("t3_wen", cyc);
        @(negedge clk);
        check("t3_busy", busy, 0);
        check("t3_radr", ram_radr, 8'hFF);
        repeat (5) @(negedge clk);
        check("t3_still_halted", halted, 1);
        check("t3_pc_held", pc, 8'hFF);
        run     = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t3_rs_halted", halted, 0);
        check("t3_rs_busy", busy, 0);
        check("t3_rs_pc", pc, 8'h00);

        // 4a: START_ADR=FE, operand fetch wraps FE, FF, 00
        run2 = 1'b1;
        @(negedge clk);
        run2 = 1'b0;
        check("t4_f0_radr", radr2, 8'hFE);
        @(negedge clk);
        check("t4_f1_radr", radr2, 8'hFF);
        @(negedge clk);
        check("t4_f2_radr", radr2, 8'h00);
        cyc = 0;
        while (wen2 !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_wen2", wen2, 1);
        check("t4_wadr2", wadr2, 8'h00);
        check("t4_wdata2", wdata2, 8'h00);
        @(negedge clk);
        check("t4_pc2", pc2, 8'h00);
        check("t4_busy2", busy2, 0);

        // 4b: self-modifying code, next F1 sees the rewritten A byte
        load(8'h00, 8'h20); load(8'h01, 8'h03); load(8'h02, 8'h03);
        load(8'h03, 8'h25); load(8'h04, 8'h21); load(8'h05, 8'h30);
        load(8'h20, 8'h01); load(8'h21, 8'h07); load(8'h24, 8'h02); load(8'h25, 8'h00);
        sb.push_back('{wadr: 8'h03, wdata: 8'h24, pc: 8'h03, halt: 1'b0});
        sb.push_back('{wadr: 8'h21, wdata: 8'h05, pc: 8'h06, halt: 1'b0});
        run = 1'b1;
        wait_wen("t4_wen1", cyc);
        @(negedge clk);
        check("t4_f0_radr_main", ram_radr, 8'h03);
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_ra_radr", ram_radr, 8'h24);
        wait_wen("t4_wen2_main", cyc);
        @(negedge clk);

        // 5: drop run in RA, restart ignored in EX, reset in RB
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t5_pc_restart", pc, 8'h00);
        load(8'h00, 8'h10); load(8'h01, 8'h11); load(8'h02, 8'h40);
        load(8'h10, 8'h01); load(8'h11, 8'h05);
        load(8'h03, 8'h12); load(8'h04, 8'h13); load(8'h05, 8'h00); load(8'h13, 8'h77);
        sb.push_back('{wadr: 8'h11, wdata: 8'h04, pc: 8'h03, halt: 1'b0});
        run = 1'b1;
        repeat (4) @(negedge clk);
        run = 1'b0;
        check("t5_busy_ra", busy, 1);
        wait_wen("t5_wen", cyc);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        check("t5_idle", busy, 0);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (4) @(negedge clk);
        check("t5_busy_rb", busy, 1);
        check("t5_rb_radr", ram_radr, 8'h13);
        rst_n = 1'b0;
        #1;
        check("t5_rst_wen", ram_wen, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_pc", pc, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_post_busy", busy, 0);
        check("t5_post_pc", pc, 8'h00);
        check("t5_no_write", mem[8'h13], 8'h77);

        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
